cpu_reset_ctrl: RTL and testbench

Reset sequencer between the button/switch front end and the CPU core. It holds the CPU in reset until the PLL reports lock, stretches the result into a fixed-width `cpu_rst` pulse, and accepts a user reset request only while the arm switch is set. A cooldown window after each release ignores further requests, and a saturating counter records user resets for LED debug.

---
 rtl/cpu_reset_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpu_reset_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_ctrl.sv
// Reset sequencer for the CPU core: holds reset until PLL lock, stretches it to a
// fixed pulse, accepts armed user requests outside a cooldown window and counts them.
module cpu_reset_ctrl #(
  parameter int RST_CYCLES      = 16,
  parameter int COOLDOWN_CYCLES = 1024,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       arm,
  input  logic       reset_req,
  output logic       cpu_rst,
  output logic       busy,
  output logic [7:0] reset_count
);

  localparam int MAX_CYCLES = (RST_CYCLES > COOLDOWN_CYCLES) ? RST_CYCLES : COOLDOWN_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD = (COOLDOWN_CYCLES > 0) ? CW'(COOLDOWN_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_ASSERT    = 2'd1,
    ST_COOLDOWN  = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] arm_sync_q;
  logic                   lock_s;
  logic                   arm_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      count_q, count_d;
  logic            cpu_rst_q;
  logic            busy_q;

  // Two-flop (or deeper) synchronizers for the asynchronous lock and arm inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      arm_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
      arm_sync_q  <= {arm_sync_q[SYNC_STAGES-2:0], arm};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign arm_s  = arm_sync_q[SYNC_STAGES-1];

  // Next-state logic; lock loss outranks everything and discards the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_ASSERT;
          cnt_d   = RST_LOAD;
        end else begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_ASSERT: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (COOLDOWN_CYCLES > 0) begin
          state_d = ST_COOLDOWN;
          cnt_d   = COOL_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_COOLDOWN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (reset_req && arm_s) begin
          state_d = ST_ASSERT;
          cnt_d   = RST_LOAD;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counters and outputs; outputs decode the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= CNT_ZERO;
      count_q   <= 8'd0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      cpu_rst_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_ASSERT);
      busy_q    <= (state_d != ST_RUN);
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign reset_count = count_q;

endmodule

// File: tb/tb_cpu_reset_ctrl.sv
// Self-checking bench for cpu_reset_ctrl: request table with a scoreboard queue,
// plus hand-written power-up, cooldown, lock-loss, async-reset and saturation sequences.
module tb_cpu_reset_ctrl;

  logic       clk;
  logic       rst_n, pll_locked, arm, reset_req;
  logic       cpu_rst, busy;
  logic [7:0] reset_count;

  logic       s_rst_n, s_lock, s_arm, s_req;
  logic       s_cpu_rst, s_busy;
  logic [7:0] s_count;

  cpu_reset_ctrl #(.RST_CYCLES(16), .COOLDOWN_CYCLES(1024), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .arm(arm), .reset_req(reset_req),
    .cpu_rst(cpu_rst), .busy(busy), .reset_count(reset_count)
  );

  cpu_reset_ctrl #(.RST_CYCLES(3), .COOLDOWN_CYCLES(0), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst_n(s_rst_n), .pll_locked(s_lock), .arm(s_arm), .reset_req(s_req),
    .cpu_rst(s_cpu_rst), .busy(s_busy), .reset_count(s_count)
  );

  typedef struct {
    logic arm;
    int   exp_len;
    int   exp_cnt;
    int   exp_busy_at;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  vec_t e;

  int total = 0;
  int bad   = 0;
  int len, first, busy_at, fall, bl, highs, late, lows, timeouts;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench at the first sample after the edge that took the request.
  task automatic pulse_req();
    @(negedge clk) reset_req = 1'b1;
    @(negedge clk) reset_req = 1'b0;
  endtask

  task automatic measure(output int f, output int l, output int b);
    l = 0;
    b = -1;
    f = int'(cpu_rst);
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      if (cpu_rst) l++;
      if (!busy && b < 0) b = k;
      if (b >= 0 && k >= 40) break;
    end
  endtask

  task automatic wait_busy_low(input int budget, output int cyc);
    cyc = -1;
    for (int k = 0; k <= budget; k++) begin
      if (!busy) begin
        cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fall(output int cyc);
    cyc = -1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (!cpu_rst) begin
        cyc = j;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{arm: 1'b1, exp_len: 16, exp_cnt: 1, exp_busy_at: 1040};
    vecs[1] = '{arm: 1'b0, exp_len: 0,  exp_cnt: 1, exp_busy_at: 0};
    vecs[2] = '{arm: 1'b1, exp_len: 16, exp_cnt: 2, exp_busy_at: 1040};
    vecs[3] = '{arm: 1'b0, exp_len: 0,  exp_cnt: 2, exp_busy_at: 0};
    vecs[4] = '{arm: 1'b1, exp_len: 16, exp_cnt: 3, exp_busy_at: 1040};

    rst_n = 1'b0; pll_locked = 1'b0; arm = 1'b0; reset_req = 1'b0;
    s_rst_n = 1'b0; s_lock = 1'b1; s_arm = 1'b1; s_req = 1'b0;

    // Power-up
    repeat (5) @(negedge clk);
    check("rst_cpu_rst", int'(cpu_rst), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_count", int'(reset_count), 0);
    rst_n = 1'b1; s_rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_lock_hold", int'(cpu_rst), 1);
    pll_locked = 1'b1; arm = 1'b1;
    wait_fall(fall);
    check("pwr_release", fall, 19);
    check("pwr_count", int'(reset_count), 0);
    wait_busy_low(1100, bl);
    check("pwr_busy", bl, 1024);

    // Request table with scoreboard
    for (int i = 0; i < 5; i++) begin
      arm = vecs[i].arm;
      repeat (4) @(negedge clk);
      sb.push_back(vecs[i]);
      pulse_req();
      measure(first, len, busy_at);
      e = sb.pop_front();
      check($sformatf("vec%0d_first", i), first, (e.exp_len > 0) ? 1 : 0);
      check($sformatf("vec%0d_len", i), len, e.exp_len);
      check($sformatf("vec%0d_count", i), int'(reset_count), e.exp_cnt);
      check($sformatf("vec%0d_busy", i), busy_at, e.exp_busy_at);
    end

    // Request 10 cycles after release lands in cooldown and is dropped
    pulse_req();
    highs = 0;
    for (int k = 0; k < 26; k++) begin
      if (k > 0) @(negedge clk);
      highs += int'(cpu_rst);
    end
    check("cd_first_pulse", highs, 16);
    pulse_req();
    late = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      late += int'(cpu_rst);
    end
    check("cd_no_pulse", late, 0);
    check("cd_busy_low", int'(busy), 0);
    check("cd_count", int'(reset_count), 4);

    // Lock loss at ASSERT cycle 5, then full hold after relock
    pulse_req();
    lows = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      lows += int'(!cpu_rst);
    end
    @(negedge clk) pll_locked = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      lows += int'(!cpu_rst);
    end
    check("ll_no_early_release", lows, 0);
    pll_locked = 1'b1;
    wait_fall(fall);
    check("ll_relock_hold", fall, 19);
    check("ll_count", int'(reset_count), 5);
    wait_busy_low(1100, bl);
    check("ll_busy", bl, 1024);

    // Request in the same cycle the synchronized lock drops
    @(negedge clk) pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_req = 1'b1;
    @(negedge clk) reset_req = 1'b0;
    check("co_cpu_rst", int'(cpu_rst), 1);
    check("co_count", int'(reset_count), 5);
    repeat (5) @(negedge clk);
    check("co_count_late", int'(reset_count), 5);
    pll_locked = 1'b1;
    wait_fall(fall);
    check("co_relock_hold", fall, 19);
    wait_busy_low(1100, bl);
    check("co_busy", bl, 1024);

    // Asynchronous reset in the middle of cooldown
    pulse_req();
    check("ar_count_before", int'(reset_count), 6);
    repeat (30) @(negedge clk);
    check("ar_cooldown_state", int'(cpu_rst), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cpu_rst", int'(cpu_rst), 1);
    check("ar_busy", int'(busy), 1);
    check("ar_count", int'(reset_count), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_hold_after", int'(cpu_rst), 1);

    // Saturation with zero cooldown
    timeouts = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) s_req = 1'b1;
      @(negedge clk) s_req = 1'b0;
      bl = -1;
      for (int k = 0; k < 20; k++) begin
        if (!s_busy) begin
          bl = k;
          break;
        end
        @(negedge clk);
      end
      if (bl < 0) timeouts++;
      if (i == 0) check("sat_busy_len", bl, 3);
      if (i == 99) check("sat_count_100", int'(s_count), 100);
      if (i == 254) check("sat_count_255", int'(s_count), 255);
    end
    check("sat_timeouts", timeouts, 0);
    check("sat_count_final", int'(s_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
